// File: rtl/fft_control_pkg.sv
// Shared types and helpers for the parametrised mixed radix-4/radix-2 FFT controller.
// Holds the FSM state enum, the bank-selection function and stage-count derivations.
package fft_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    localparam int DEFAULT_ADDR_W = 9;

    function automatic int stages_for(input int addr_w);
        return (addr_w + 3) / 2;
    endfunction

    function automatic bit last_radix2_for(input int addr_w);
        return (addr_w % 2) == 1;
    endfunction

    localparam int STAGES      = stages_for(DEFAULT_ADDR_W);
    localparam bit LAST_RADIX2 = last_radix2_for(DEFAULT_ADDR_W);

    // Bank of a point index: base-4 digit sum mod 4, so the four butterfly inputs never collide.
    function automatic logic [1:0] digit_sum_mod4(input logic [31:0] g);
        logic [1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc + g[2*i +: 2];
        end
        return acc;
    endfunction

endpackage

// File: rtl/fft_ctrl_delay.sv
// Fixed-depth shift register carrying the read-side bundle to the write side.
// clr empties the whole pipe on the next edge, as reset does.
module fft_ctrl_delay
    import fft_control_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pipe_d[i] = '0;
        end
        if (!clr) begin
            pipe_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_control_param.sv
// In-place four-bank FFT address sequencer for N = 4*2^ADDR_W points, radix-2 last stage when ADDR_W is odd.
// Define FFT_CONTROL_ABORT_EN to add the iABORT port that returns the controller to IDLE mid-run.
module fft_control_param
    import fft_control_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int BUT_LAT = 4
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
`ifdef FFT_CONTROL_ABORT_EN
    input  logic              iABORT,
`endif
    output logic [1:0]        oBANK_RD_ROT,
    output logic [1:0]        oBANK_WR_ROT,
    output logic [ADDR_W-1:0] oADDR_RD_0,
    output logic [ADDR_W-1:0] oADDR_RD_1,
    output logic [ADDR_W-1:0] oADDR_RD_2,
    output logic [ADDR_W-1:0] oADDR_RD_3,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic [ADDR_W-1:0] oADDR_COEF,
    output logic              oWE_A,
    output logic              oWE_B,
    output logic              oSOURCE_DATA,
    output logic              oSOURCE_CONT,
    output logic              oBUT_TYPE,
    output logic              oRDY
);

    localparam int N_STAGES = stages_for(ADDR_W);
    localparam bit HAS_R2   = last_radix2_for(ADDR_W);
    localparam int STAGE_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int DRAIN_W  = $clog2(BUT_LAT + 1);
    localparam int G_W      = ADDR_W + 2;
    localparam int DLY_W    = 4 * ADDR_W + 4;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(BUT_LAT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [STAGE_W-1:0]  stage_q, stage_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                abort;

`ifdef FFT_CONTROL_ABORT_EN
    assign abort = iABORT;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_READ;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            ST_READ: begin
                k_d = k_q + 1'b1;
                if (k_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 1'b1;
                // The next stage only starts reading once the previous stage's last write has gone out.
                if (drain_q == DRAIN_LAST) begin
                    k_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                    end else begin
                        state_d = ST_READ;
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            k_d     = '0;
            stage_d = '0;
            drain_d = '0;
        end
    end

    logic              reading;
    logic              radix2_stage;
    int                pos;
    logic [G_W-1:0]    k_ext, lo_mask, hi_mask;
    logic [1:0]        j_bits;
    logic [G_W-1:0]    g [4];
    logic [1:0]        g_bank [4];
    logic [ADDR_W-1:0] addr_rd [4];
    logic [ADDR_W-1:0] k_masked, coef;
    logic [1:0]        rot_rd;
    logic              we_a_rd, we_b_rd;

    always_comb begin
        reading      = (state_q == ST_READ);
        radix2_stage = HAS_R2 && (stage_q == STAGE_LAST);
        pos          = 2 * int'(stage_q);
        k_ext        = G_W'(k_q);
        lo_mask      = ~({G_W{1'b1}} << pos);
        hi_mask      = {G_W{1'b1}} << (pos + 2);
        j_bits       = '0;
        rot_rd       = '0;
        coef         = '0;
        k_masked     = '0;
        for (int j = 0; j < 4; j++) begin
            g[j]       = '0;
            g_bank[j]  = '0;
            addr_rd[j] = '0;
        end
        // Butterfly input j: insert digit j at position 2s, or split across both ends for the radix-2 pass.
        for (int j = 0; j < 4; j++) begin
            j_bits = 2'(j);
            if (radix2_stage) begin
                g[j] = {j_bits[0], k_q[ADDR_W-1:1], j_bits[1], k_q[0]};
            end else begin
                g[j] = ((k_ext << 2) & hi_mask) | (G_W'(j_bits) << pos) | (k_ext & lo_mask);
            end
            g_bank[j] = digit_sum_mod4(32'(g[j]));
        end
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) begin
                if (reading && g_bank[j] == 2'(b)) begin
                    addr_rd[b] = g[j][G_W-1:2];
                end
            end
        end
        for (int b = 0; b < ADDR_W; b++) begin
            k_masked[b] = k_q[b] & (b < pos);
        end
        if (reading) begin
            rot_rd = g_bank[0];
            if (pos <= ADDR_W) begin
                coef = k_masked << (ADDR_W - pos);
            end else begin
                coef = k_masked >> (pos - ADDR_W);
            end
        end
        we_a_rd = reading & stage_q[0];
        we_b_rd = reading & ~stage_q[0];
    end

    logic [DLY_W-1:0] wr_bus;

    fft_ctrl_delay #(
        .WIDTH (DLY_W),
        .DEPTH (BUT_LAT)
    ) u_wr_delay (
        .clk   (iCLK),
        .rst_n (iRESET),
        .clr   (abort),
        .din   ({we_a_rd, we_b_rd, rot_rd, addr_rd[3], addr_rd[2], addr_rd[1], addr_rd[0]}),
        .dout  (wr_bus)
    );

    assign {oWE_A, oWE_B, oBANK_WR_ROT, oADDR_WR_3, oADDR_WR_2, oADDR_WR_1, oADDR_WR_0} = wr_bus;

    assign oBANK_RD_ROT = rot_rd;
    assign oADDR_RD_0   = addr_rd[0];
    assign oADDR_RD_1   = addr_rd[1];
    assign oADDR_RD_2   = addr_rd[2];
    assign oADDR_RD_3   = addr_rd[3];
    assign oADDR_COEF   = coef;
    assign oSOURCE_DATA = (state_q != ST_IDLE) & stage_q[0];
    assign oSOURCE_CONT = (state_q != ST_IDLE);
    assign oBUT_TYPE    = reading & radix2_stage;
    assign oRDY         = (state_q == ST_IDLE);

endmodule

// File: doc/fft_control_param.md
Name: fft_control_param

Overview:
Parametrised successor to the fixed 2048-point FFT controller. Sequences a mixed radix-4/radix-2, in-place, four-bank FFT of N = 4*2^ADDR_W points. Generates per-bank read/write addresses, bank rotations, twiddle address, ping-pong write enables and butterfly type. Sits between the top-level FFT FSM and the four memory banks, coefficient ROM and butterfly unit.

Parameters:
ADDR_W, 9, bank address width; bank depth D = 2^ADDR_W, N = 4*D
BUT_LAT, 4, butterfly pipeline latency in cycles (read to write), >= 1
STAGES, derived = ceil((ADDR_W+2)/2); last stage is radix-2 when ADDR_W is odd

Ports:
iCLK  in  1  clock
iRESET  in  1  synchronous reset, active-low
iSTART  in  1  start pulse, sampled only in IDLE
oBANK_RD_ROT  out  2  bank index holding butterfly input 0 (read side)
oBANK_WR_ROT  out  2  oBANK_RD_ROT delayed BUT_LAT cycles
oADDR_RD_0..3  out  ADDR_W each  read address per bank
oADDR_WR_0..3  out  ADDR_W each  write address per bank (read addresses delayed BUT_LAT)
oADDR_COEF  out  ADDR_W  twiddle ROM address
oWE_A, oWE_B  out  1 each  write enable, memory A / memory B
oSOURCE_DATA  out  1  0 = butterfly reads A, 1 = reads B
oSOURCE_CONT  out  1  1 = controller owns memories
oBUT_TYPE  out  1  0 = radix-4, 1 = radix-2
oRDY  out  1  1 = idle/finished

Behaviour:
- Clock and reset: one clock, iCLK. iRESET is synchronous and active-low. Reset forces IDLE on the next edge: all addresses 0, rotations 0, oWE_A/oWE_B/oSOURCE_*/oBUT_TYPE 0, oRDY 1. Applies mid-run as well.
- States: IDLE -> (iSTART) READ -> (k = D-1) DRAIN -> (BUT_LAT cycles) READ of stage s+1, or IDLE after the last stage.
- iSTART outside IDLE is ignored.
- Stage s, counter k = 0..D-1, one k per cycle.
  - Radix-4: g_j = k with 2-bit digit j inserted at bit 2s (ADDR_W+2 bits).
  - Radix-2 (final, odd ADDR_W): g_j = {j[0], k[ADDR_W-1:1], j[1], k[0]}.
  - bank(g) = sum of base-4 digits of g mod 4; addr(g) = g >> 2.
  - oADDR_RD_[bank(g_j)] = addr(g_j); oBANK_RD_ROT = bank(g_0).
- oADDR_COEF = (k & (4^s - 1)) << (ADDR_W - 2s), truncated to ADDR_W bits; 0 in stage 0 and in IDLE/DRAIN.
- Write side: oADDR_WR_*, oBANK_WR_ROT and the enable are the read side delayed exactly BUT_LAT cycles.
  - Even s: read A, write B (oWE_B).
  - Odd s: read B, write A (oWE_A).
  - Each enable is high exactly D cycles per stage.
- oSOURCE_DATA = s[0] while running. oBUT_TYPE = 1 only during radix-2 stage reads.
- oSOURCE_CONT = 1 and oRDY = 0 from the cycle after iSTART until the last write. No read/write overlap between stages.
- Total busy time = STAGES*(D+BUT_LAT) cycles.

Optional Feature:
- FFT_CONTROL_ABORT_EN defined: adds port iABORT (in, 1).
  - iABORT high in any non-IDLE state -> IDLE next edge with reset output values.
  - iABORT has priority over iSTART.
- Undefined: no port; the run always completes.

Decomposition:
- fft_control_pkg: state enum (IDLE/READ/DRAIN), function digit_sum_mod4, derived constants STAGES and LAST_RADIX2.
- One sub-module, fft_ctrl_delay: parametrised width/depth shift register used for the BUT_LAT write-side delay.

Test Plan:
1. Defaults. Reset low 2 cycles, then idle -> oRDY=1, all addresses 0, oWE_A=oWE_B=0.
2. iSTART pulse, stage 0 -> first read cycle: all oADDR_RD=0, ROT=0. Next (k=1): all addresses 1, ROT=1. oWE_B rises 4 cycles after the first read, with oADDR_WR_0=0.
3. Stage 1, k=5 -> oADDR_COEF=128, oSOURCE_DATA=1, oWE_A active after the drain.
4. Stage 5 (radix-2), k=0 -> oBUT_TYPE=1 and:
   - bank0 addr 0
   - bank1 addr 256
   - bank2 addr 0
   - bank3 addr 256
5. Full run.
   - oRDY low exactly 3096 cycles.
   - A second iSTART mid-run is ignored.
   - iRESET low mid-run -> IDLE next cycle.
6. ADDR_W=8 -> all radix-4, oBUT_TYPE never 1, busy 1300 cycles. With FFT_CONTROL_ABORT_EN, iABORT at cycle 500 -> oRDY=1 next cycle.
